// File: rtl/level_safe_driver.sv
// Drives a single-bit external level from a ready/valid request and holds every edge for Hold_Cycles enabled cycles.
// Optional pulse requests are compiled in when LEVEL_SAFE_DRIVER_PULSE_EN is defined.
module level_safe_driver #(
  parameter int   Hold_Cycles = 32,
  parameter logic Idle_Level  = 1'b0
) (
  input  logic clk,
  input  logic clk_en,
  input  logic async_rst,
  input  logic req_valid,
  input  logic req_level,
  input  logic req_pulse,
  output logic req_ready,
  output logic io_out,
  output logic busy,
  output logic done
);

  localparam int              CntW = $clog2(Hold_Cycles + 1);
  localparam logic [CntW-1:0] Load = CntW'(Hold_Cycles - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
`ifdef LEVEL_SAFE_DRIVER_PULSE_EN
  localparam logic [1:0] PULSE_ACT = 2'd2;
  localparam logic [1:0] PULSE_REC = 2'd3;
`endif

  generate
    if (Hold_Cycles < 1) begin : g_bad_hold
      $error("level_safe_driver: Hold_Cycles must be at least 1");
    end
  endgenerate

  logic [1:0]      state;
  logic [CntW-1:0] cnt;
  logic            is_pulse;

`ifdef LEVEL_SAFE_DRIVER_PULSE_EN
  assign is_pulse = req_pulse;
`else
  // Pulse requests degrade to level requests; the port stays for pin compatibility.
  logic unused_req_pulse;
  assign unused_req_pulse = req_pulse;
  assign is_pulse         = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      io_out <= Idle_Level;
      done   <= 1'b0;
    end else begin
      // done is a strobe: it never survives past one clock, even if clk_en drops.
      done <= 1'b0;
      if (clk_en) begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              if (is_pulse) begin
`ifdef LEVEL_SAFE_DRIVER_PULSE_EN
                io_out <= ~io_out;
                cnt    <= Load;
                state  <= PULSE_ACT;
`endif
              end else if (req_level != io_out) begin
                io_out <= req_level;
                cnt    <= Load;
                state  <= HOLD;
              end else begin
                done <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (cnt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
`ifdef LEVEL_SAFE_DRIVER_PULSE_EN
          PULSE_ACT: begin
            if (cnt == '0) begin
              io_out <= ~io_out;
              cnt    <= Load;
              state  <= PULSE_REC;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          PULSE_REC: begin
            if (cnt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_level_safe_driver.sv
// Directed bench for level_safe_driver with Hold_Cycles=32, Idle_Level=0.
module tb_level_safe_driver;

  logic clk = 1'b0;
  logic clk_en, async_rst, req_valid, req_level, req_pulse;
  logic req_ready, io_out, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  level_safe_driver #(.Hold_Cycles(32), .Idle_Level(1'b0)) dut (
    .clk(clk), .clk_en(clk_en), .async_rst(async_rst),
    .req_valid(req_valid), .req_level(req_level), .req_pulse(req_pulse),
    .req_ready(req_ready), .io_out(io_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clocks until done (bounded); also counts cycles where io_out left lvl.
  task automatic wait_done(input logic lvl, output int n, output int moved);
    n = 0;
    moved = 0;
    while (n < 200) begin
      tick();
      n++;
      if (io_out !== lvl) moved++;
      if (done === 1'b1) break;
    end
  endtask

  int n, moved;

  initial begin
    async_rst = 1'b1; clk_en = 1'b1;
    req_valid = 1'b0; req_level = 1'b0; req_pulse = 1'b0;
    #2;
    check("rst_io", io_out, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick(); tick();
    async_rst = 1'b0;
    tick(); tick();
    check("post_rst_io", io_out, 0);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    // Level edge to 1; a queued request to 0 is held by the requester.
    req_valid = 1'b1; req_level = 1'b1;
    tick();
    check("lvl_io", io_out, 1);
    check("lvl_busy", busy, 1);
    check("lvl_ready", req_ready, 0);
    check("lvl_done", done, 0);
    req_level = 1'b0;
    wait_done(1'b1, n, moved);
    check("hold_len", n, 32);
    check("hold_stable", moved, 0);
    check("hold_ready", req_ready, 1);
    check("hold_busy", busy, 0);
    tick();
    check("second_edge_io", io_out, 0);
    check("second_edge_busy", busy, 1);
    check("second_edge_done", done, 0);
    req_valid = 1'b0;
    wait_done(1'b0, n, moved);
    check("hold2_len", n, 32);
    check("hold2_stable", moved, 0);

    // Request matching the current level is a no-op.
    tick();
    req_valid = 1'b1; req_level = 1'b0;
    tick();
    req_valid = 1'b0;
    check("noop_io", io_out, 0);
    check("noop_busy", busy, 0);
    check("noop_done", done, 1);
    tick();
    check("noop_done_clear", done, 0);

    // clk_en alternating 0/1 during hold doubles the wall-clock span.
    req_valid = 1'b1; req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    check("en_edge_io", io_out, 1);
    n = 0; moved = 0;
    while (n < 200) begin
      clk_en = n[0];
      tick();
      n++;
      if (io_out !== 1'b1) moved++;
      if (done === 1'b1) break;
    end
    check("en_hold_clocks", n, 64);
    check("en_hold_stable", moved, 0);
    clk_en = 1'b0;
    tick();
    check("en_done_clear", done, 0);

    // A valid request is ignored while clk_en is low.
    req_valid = 1'b1; req_level = 1'b0;
    tick();
    check("gated_io", io_out, 1);
    check("gated_busy", busy, 0);
    clk_en = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ungated_io", io_out, 0);
    wait_done(1'b0, n, moved);
    check("hold3_len", n, 32);

    // Reset mid-hold returns to reset values without a clock edge.
    tick();
    req_valid = 1'b1; req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("pre_rst_io", io_out, 1);
    #2 async_rst = 1'b1;
    #1;
    check("midrst_io", io_out, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    tick();
    async_rst = 1'b0;
    tick();

`ifdef LEVEL_SAFE_DRIVER_PULSE_EN
    req_valid = 1'b1; req_pulse = 1'b1; req_level = 1'b0;
    tick();
    req_valid = 1'b0; req_pulse = 1'b0;
    check("pulse_io", io_out, 1);
    check("pulse_busy", busy, 1);
    n = 0;
    while (n < 200 && io_out === 1'b1) begin
      tick();
      n++;
    end
    check("pulse_active_len", n, 32);
    wait_done(1'b0, moved, moved);
    check("pulse_done_at", n + moved, 64);
    check("pulse_end_io", io_out, 0);
    tick();
    req_valid = 1'b1; req_pulse = 1'b1;
    tick();
    req_valid = 1'b0; req_pulse = 1'b0;
    tick(); tick();
    check("pulse_pre_rst_io", io_out, 1);
    #2 async_rst = 1'b1;
    #1;
    check("pulse_rst_io", io_out, 0);
    check("pulse_rst_ready", req_ready, 1);
    tick();
    async_rst = 1'b0;
    tick();
`else
    req_valid = 1'b1; req_pulse = 1'b1; req_level = 1'b0;
    tick();
    req_valid = 1'b0; req_pulse = 1'b0;
    check("nopulse_io", io_out, 0);
    check("nopulse_busy", busy, 0);
    check("nopulse_done", done, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
